// File: rtl/issue_queue.sv
// In-order circular issue queue between decode and the execute pipes: buffers
// up to WIDTH instructions per cycle and issues a hazard-free, lane-routed group.
module issue_queue #(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 8,
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int REG_BITS   = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            enq_valid,
    input  logic [WIDTH*INST_WIDTH-1:0] enq_inst,
    input  logic [WIDTH*ADDR_WIDTH-1:0] enq_pc,
    input  logic [WIDTH*ID_WIDTH-1:0]   enq_id,
    input  logic [2*WIDTH-1:0]          enq_class,
    input  logic [2*WIDTH-1:0]          enq_src,
    input  logic [2*WIDTH-1:0]          enq_dst,
    input  logic [WIDTH-1:0]            enq_load,
    output logic                        enq_ready,
    input  logic                        iss_stall,
    output logic [WIDTH-1:0]            iss_valid,
    output logic [WIDTH*INST_WIDTH-1:0] iss_inst,
    output logic [WIDTH*ADDR_WIDTH-1:0] iss_pc,
    output logic [WIDTH*ID_WIDTH-1:0]   iss_id,
    output logic [$clog2(DEPTH):0]      count,
    output logic [2:0]                  hazard
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_NOP = 2'b11;
    localparam logic [1:0] DST_RT  = 2'b01;
    localparam logic [1:0] DST_RD  = 2'b10;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ID_WIDTH-1:0]   id;
        logic [1:0]            cls;
        logic [1:0]            src;
        logic [1:0]            dst;
        logic                  load;
    } entry_t;

    entry_t              ent_q [DEPTH];
    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [CNT_W-1:0]    count_q;
    logic                sb_valid_q;
    logic [REG_BITS-1:0] sb_reg_q;

    function automatic logic [REG_BITS-1:0] rs_of(input entry_t e);
        return e.inst[21 +: REG_BITS];
    endfunction

    function automatic logic [REG_BITS-1:0] rt_of(input entry_t e);
        return e.inst[16 +: REG_BITS];
    endfunction

    function automatic logic [REG_BITS-1:0] dst_of(input entry_t e);
        return (e.dst == DST_RD) ? e.inst[11 +: REG_BITS] : rt_of(e);
    endfunction

    function automatic logic has_dst(input entry_t e);
        return (e.dst == DST_RT) || (e.dst == DST_RD);
    endfunction

    function automatic logic reads(input entry_t e, input logic [REG_BITS-1:0] r);
        return (e.src[0] && (rs_of(e) == r)) || (e.src[1] && (rt_of(e) == r));
    endfunction

    // Handshake: a group is taken at a posedge when enq_ready && |enq_valid and no
    // flush; enq_ready looks only at the registered count, never at same-cycle issue.
    logic             enq_fire;
    logic [CNT_W-1:0] enq_n;
    logic [CNT_W-1:0] enq_add;
    logic [PTR_W-1:0] enq_off [WIDTH];
    entry_t           enq_e [WIDTH];

    assign enq_ready = (count_q <= CNT_W'(DEPTH - WIDTH));
    assign enq_fire  = enq_ready && (|enq_valid);
    assign enq_add   = enq_fire ? enq_n : '0;

    always_comb begin
        logic [CNT_W-1:0] run;
        run = '0;
        for (int k = 0; k < WIDTH; k++) begin
            enq_off[k]    = tail_q + run[PTR_W-1:0];
            enq_e[k].inst = enq_inst[k*INST_WIDTH +: INST_WIDTH];
            enq_e[k].pc   = enq_pc[k*ADDR_WIDTH +: ADDR_WIDTH];
            enq_e[k].id   = enq_id[k*ID_WIDTH +: ID_WIDTH];
            enq_e[k].cls  = enq_class[2*k +: 2];
            enq_e[k].src  = enq_src[2*k +: 2];
            enq_e[k].dst  = enq_dst[2*k +: 2];
            enq_e[k].load = enq_load[k];
            if (enq_valid[k]) run = run + CNT_W'(1);
        end
        enq_n = run;
    end

    // Oldest-first scan of the head window; the first blocked slot ends the group.
    entry_t           slot_e [WIDTH];
    logic [WIDTH-1:0] sel;
    logic [CNT_W-1:0] deq_n;
    logic [CNT_W-1:0] deq_eff;
    logic [2:0]       hazard_c;

    always_comb begin
        logic             scan, hz_load, hz_split, hz_steer, mem_used, br_used;
        logic [WIDTH-1:0] s;
        logic [CNT_W-1:0] n, lanes_used;
        scan       = 1'b1;
        mem_used   = 1'b0;
        br_used    = 1'b0;
        hz_load    = 1'b0;
        hz_split   = 1'b0;
        hz_steer   = 1'b0;
        s          = '0;
        n          = '0;
        lanes_used = '0;
        hazard_c   = 3'b000;
        for (int i = 0; i < WIDTH; i++) begin
            slot_e[i] = ent_q[head_q + PTR_W'(i)];
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (scan) begin
                if (CNT_W'(i) >= count_q) begin
                    scan = 1'b0;
                end else if (slot_e[i].cls == CLS_NOP) begin
                    s[i] = 1'b1;
                    n    = n + CNT_W'(1);
                end else begin
                    hz_load  = sb_valid_q && reads(slot_e[i], sb_reg_q);
                    hz_split = 1'b0;
                    for (int j = 0; j < WIDTH; j++) begin
                        if (j < i && s[j] && slot_e[j].cls != CLS_NOP && has_dst(slot_e[j])) begin
                            if (reads(slot_e[i], dst_of(slot_e[j]))) hz_split = 1'b1;
                            if (has_dst(slot_e[i]) && dst_of(slot_e[i]) == dst_of(slot_e[j]))
                                hz_split = 1'b1;
                        end
                    end
                    hz_steer = (slot_e[i].cls == CLS_MEM && mem_used) ||
                               (slot_e[i].cls == CLS_BR && br_used) ||
                               (lanes_used >= CNT_W'(WIDTH));
                    if (hz_load || hz_split || hz_steer) begin
                        scan     = 1'b0;
                        hazard_c = hz_load ? 3'b001 : (hz_split ? 3'b010 : 3'b100);
                    end else begin
                        s[i]       = 1'b1;
                        n          = n + CNT_W'(1);
                        lanes_used = lanes_used + CNT_W'(1);
                        if (slot_e[i].cls == CLS_MEM) mem_used = 1'b1;
                        if (slot_e[i].cls == CLS_BR)  br_used  = 1'b1;
                    end
                end
            end
        end
        sel   = s;
        deq_n = n;
    end

    assign deq_eff = iss_stall ? '0 : deq_n;

    // Memory pins lane 0, branch pins lane WIDTH-1, ALU ops fill what is left.
    entry_t              lane_e [WIDTH];
    logic [WIDTH-1:0]    lane_v;
    logic                sb_next_v;
    logic [REG_BITS-1:0] sb_next_reg;

    always_comb begin
        logic [WIDTH-1:0] v;
        logic             placed;
        v           = '0;
        placed      = 1'b0;
        sb_next_v   = 1'b0;
        sb_next_reg = '0;
        for (int k = 0; k < WIDTH; k++) lane_e[k] = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel[i] && slot_e[i].cls == CLS_MEM) begin
                v[0]      = 1'b1;
                lane_e[0] = slot_e[i];
                if (slot_e[i].load && has_dst(slot_e[i])) begin
                    sb_next_v   = 1'b1;
                    sb_next_reg = dst_of(slot_e[i]);
                end
            end else if (sel[i] && slot_e[i].cls == CLS_BR) begin
                v[WIDTH-1]      = 1'b1;
                lane_e[WIDTH-1] = slot_e[i];
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (sel[i] && slot_e[i].cls == CLS_ALU) begin
                placed = 1'b0;
                for (int k = 0; k < WIDTH; k++) begin
                    if (!placed && !v[k]) begin
                        v[k]      = 1'b1;
                        lane_e[k] = slot_e[i];
                        placed    = 1'b1;
                    end
                end
            end
        end
        lane_v = v;
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && enq_fire) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (enq_valid[k]) ent_q[enq_off[k]] <= enq_e[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            sb_valid_q <= 1'b0;
            sb_reg_q   <= '0;
            iss_valid  <= '0;
            iss_inst   <= '0;
            iss_pc     <= '0;
            iss_id     <= '0;
        end else begin
            if (enq_fire) tail_q <= tail_q + enq_n[PTR_W-1:0];
            count_q <= count_q + enq_add - deq_eff;
            if (!iss_stall) begin
                head_q     <= head_q + deq_n[PTR_W-1:0];
                sb_valid_q <= sb_next_v;
                sb_reg_q   <= sb_next_reg;
                iss_valid  <= lane_v;
                for (int k = 0; k < WIDTH; k++) begin
                    iss_inst[k*INST_WIDTH +: INST_WIDTH] <= lane_e[k].inst;
                    iss_pc[k*ADDR_WIDTH +: ADDR_WIDTH]   <= lane_e[k].pc;
                    iss_id[k*ID_WIDTH +: ID_WIDTH]       <= lane_e[k].id;
                end
            end
        end
    end

    assign count  = count_q;
    assign hazard = hazard_c;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: hand-computed expectations for reset, pairing,
// hazard splits, steering, load-use bubble, full/stall and flush.
module tb_issue_queue;

    localparam int WIDTH = 2;
    localparam logic [1:0] C_ALU = 2'b00;
    localparam logic [1:0] C_MEM = 2'b01;
    localparam logic [1:0] C_BR  = 2'b10;
    localparam logic [1:0] C_NOP = 2'b11;
    localparam logic [1:0] D_NO  = 2'b00;
    localparam logic [1:0] D_RT  = 2'b01;
    localparam logic [1:0] D_RD  = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  enq_valid;
    logic [63:0] enq_inst;
    logic [63:0] enq_pc;
    logic [15:0] enq_id;
    logic [3:0]  enq_class;
    logic [3:0]  enq_src;
    logic [3:0]  enq_dst;
    logic [1:0]  enq_load;
    logic        enq_ready;
    logic        iss_stall;
    logic [1:0]  iss_valid;
    logic [63:0] iss_inst;
    logic [63:0] iss_pc;
    logic [15:0] iss_id;
    logic [3:0]  count;
    logic [2:0]  hazard;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    issue_queue #(.WIDTH(2), .DEPTH(8), .INST_WIDTH(32), .ADDR_WIDTH(32),
                  .ID_WIDTH(8), .REG_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_pc(enq_pc), .enq_id(enq_id),
        .enq_class(enq_class), .enq_src(enq_src), .enq_dst(enq_dst), .enq_load(enq_load),
        .enq_ready(enq_ready), .iss_stall(iss_stall),
        .iss_valid(iss_valid), .iss_inst(iss_inst), .iss_pc(iss_pc), .iss_id(iss_id),
        .count(count), .hazard(hazard)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] pc_of(input logic [7:0] id);
        return 32'h100 + {22'd0, id, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_lane(input string tag, input int lane, input bit v,
                              input logic [31:0] inst, input logic [7:0] id);
        check({tag, "_inst"}, 64'(iss_inst[lane*32 +: 32]), v ? 64'(inst) : 64'd0);
        check({tag, "_id"},   64'(iss_id[lane*8 +: 8]),     v ? 64'(id) : 64'd0);
        check({tag, "_pc"},   64'(iss_pc[lane*32 +: 32]),   v ? 64'(pc_of(id)) : 64'd0);
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [31:0] i0, input logic [1:0] c0, input logic [1:0] s0,
                         input logic [1:0] d0, input logic l0, input logic [7:0] id0,
                         input logic [31:0] i1, input logic [1:0] c1, input logic [1:0] s1,
                         input logic [1:0] d1, input logic l1, input logic [7:0] id1);
        enq_valid = v;
        enq_inst  = {i1, i0};
        enq_pc    = {pc_of(id1), pc_of(id0)};
        enq_id    = {id1, id0};
        enq_class = {c1, c0};
        enq_src   = {s1, s0};
        enq_dst   = {d1, d0};
        enq_load  = {l1, l0};
    endtask

    task automatic idle();
        enq_valid = '0;
        enq_inst  = '0;
        enq_pc    = '0;
        enq_id    = '0;
        enq_class = '0;
        enq_src   = '0;
        enq_dst   = '0;
        enq_load  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] add1, addi, a3, b3, jmp, lw1, lw2, sw1, lw3, add5, add6, sw6, add7;
        add1 = mk(6'h20, 5'd1, 5'd2, 5'd3);
        addi = mk(6'h08, 5'd4, 5'd5, 5'd0);
        a3   = mk(6'h20, 5'd1, 5'd2, 5'd3);
        b3   = mk(6'h21, 5'd3, 5'd4, 5'd6);
        jmp  = mk(6'h02, 5'd0, 5'd0, 5'd0);
        lw1  = mk(6'h23, 5'd1, 5'd2, 5'd0);
        lw2  = mk(6'h23, 5'd8, 5'd7, 5'd0);
        sw1  = mk(6'h2b, 5'd10, 5'd9, 5'd0);
        lw3  = mk(6'h23, 5'd1, 5'd2, 5'd0);
        add5 = mk(6'h20, 5'd2, 5'd1, 5'd4);
        add6 = mk(6'h20, 5'd12, 5'd13, 5'd11);
        sw6  = mk(6'h2b, 5'd15, 5'd14, 5'd0);
        add7 = mk(6'h20, 5'd21, 5'd22, 5'd20);

        // Reset
        rst_n = 1'b0; flush = 1'b0; iss_stall = 1'b0; idle();
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        check("rst_valid", 64'(iss_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(enq_ready), 64'd1);
        check("rst_hazard", 64'(hazard), 64'd0);
        check("rst_inst", iss_inst, 64'd0);

        // Independent pair issues together
        drive(2'b11, add1, C_ALU, 2'b11, D_RD, 1'b0, 8'd1, addi, C_ALU, 2'b01, D_RT, 1'b0, 8'd2);
        step(); idle();
        check("pair_count_q", 64'(count), 64'd2);
        check("pair_latency", 64'(iss_valid), 64'd0);
        step();
        check("pair_valid", 64'(iss_valid), 64'd3);
        check_lane("pair_l0", 0, 1'b1, add1, 8'd1);
        check_lane("pair_l1", 1, 1'b1, addi, 8'd2);
        check("pair_count", 64'(count), 64'd0);

        // RAW split
        drive(2'b11, a3, C_ALU, 2'b11, D_RD, 1'b0, 8'd3, b3, C_ALU, 2'b11, D_RD, 1'b0, 8'd4);
        step(); idle();
        check("raw_hazard", 64'(hazard), 64'd2);
        step();
        check("raw_valid1", 64'(iss_valid), 64'd1);
        check_lane("raw_first", 0, 1'b1, a3, 8'd3);
        check_lane("raw_l1_zero", 1, 1'b0, 32'd0, 8'd0);
        check("raw_count1", 64'(count), 64'd1);
        check("raw_hazard_clear", 64'(hazard), 64'd0);
        step();
        check("raw_valid2", 64'(iss_valid), 64'd1);
        check_lane("raw_second", 0, 1'b1, b3, 8'd4);
        check("raw_count2", 64'(count), 64'd0);

        // Steer swap: branch older than load
        drive(2'b11, jmp, C_BR, 2'b00, D_NO, 1'b0, 8'd5, lw1, C_MEM, 2'b01, D_RT, 1'b1, 8'd6);
        step(); idle();
        check("swap_hazard", 64'(hazard), 64'd0);
        step();
        check("swap_valid", 64'(iss_valid), 64'd3);
        check_lane("swap_l0", 0, 1'b1, lw1, 8'd6);
        check_lane("swap_l1", 1, 1'b1, jmp, 8'd5);

        // Two memory ops serialize
        drive(2'b11, lw2, C_MEM, 2'b01, D_RT, 1'b1, 8'd7, sw1, C_MEM, 2'b11, D_NO, 1'b0, 8'd8);
        step(); idle();
        check("mm_count", 64'(count), 64'd2);
        check("mm_hazard", 64'(hazard), 64'd4);
        check("mm_idle_valid", 64'(iss_valid), 64'd0);
        step();
        check("mm_valid1", 64'(iss_valid), 64'd1);
        check_lane("mm_lw", 0, 1'b1, lw2, 8'd7);
        check("mm_hazard_clear", 64'(hazard), 64'd0);
        step();
        check("mm_valid2", 64'(iss_valid), 64'd1);
        check_lane("mm_sw", 0, 1'b1, sw1, 8'd8);
        check("mm_count2", 64'(count), 64'd0);

        // Load-use: one bubble
        drive(2'b11, lw3, C_MEM, 2'b01, D_RT, 1'b1, 8'd9, add5, C_ALU, 2'b11, D_RD, 1'b0, 8'd10);
        step(); idle();
        check("lu_hazard_raw", 64'(hazard), 64'd2);
        step();
        check("lu_valid1", 64'(iss_valid), 64'd1);
        check_lane("lu_lw", 0, 1'b1, lw3, 8'd9);
        check("lu_hazard_load", 64'(hazard), 64'd1);
        check("lu_count1", 64'(count), 64'd1);
        step();
        check("lu_bubble", 64'(iss_valid), 64'd0);
        check("lu_count_bubble", 64'(count), 64'd1);
        check("lu_hazard_clear", 64'(hazard), 64'd0);
        step();
        check("lu_valid2", 64'(iss_valid), 64'd1);
        check_lane("lu_add", 0, 1'b1, add5, 8'd10);

        // ALU older than memory: memory still takes lane 0
        drive(2'b11, add6, C_ALU, 2'b11, D_RD, 1'b0, 8'd11, sw6, C_MEM, 2'b11, D_NO, 1'b0, 8'd12);
        step(); idle();
        step();
        check("am_valid", 64'(iss_valid), 64'd3);
        check_lane("am_l0", 0, 1'b1, sw6, 8'd12);
        check_lane("am_l1", 1, 1'b1, add6, 8'd11);

        // nop takes no lane
        drive(2'b11, 32'd0, C_NOP, 2'b00, D_NO, 1'b0, 8'd13, add7, C_ALU, 2'b11, D_RD, 1'b0, 8'd14);
        step(); idle();
        step();
        check("nop_valid", 64'(iss_valid), 64'd1);
        check_lane("nop_l0", 0, 1'b1, add7, 8'd14);
        check_lane("nop_l1", 1, 1'b0, 32'd0, 8'd0);
        check("nop_count", 64'(count), 64'd0);

        // Stall fills the queue; issue register holds
        iss_stall = 1'b1;
        for (int g = 0; g < 4; g++) begin
            drive(2'b11, mk(6'h20, 5'd1, 5'd2, 5'(3 + g)), C_ALU, 2'b11, D_RD, 1'b0, 8'(20 + 2*g),
                  mk(6'h20, 5'd6, 5'd7, 5'(10 + g)), C_ALU, 2'b11, D_RD, 1'b0, 8'(21 + 2*g));
            step();
        end
        idle();
        check("full_count", 64'(count), 64'd8);
        check("full_ready", 64'(enq_ready), 64'd0);
        check("stall_hold_valid", 64'(iss_valid), 64'd1);
        check_lane("stall_hold_l0", 0, 1'b1, add7, 8'd14);
        drive(2'b11, add1, C_ALU, 2'b11, D_RD, 1'b0, 8'd40, addi, C_ALU, 2'b01, D_RT, 1'b0, 8'd41);
        step(); idle();
        check("full_ignore", 64'(count), 64'd8);

        // Flush drops the queue and the same-cycle group
        flush = 1'b1;
        drive(2'b11, add1, C_ALU, 2'b11, D_RD, 1'b0, 8'd42, addi, C_ALU, 2'b01, D_RT, 1'b0, 8'd43);
        step(); flush = 1'b0; idle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(iss_valid), 64'd0);
        check("flush_ready", 64'(enq_ready), 64'd1);
        check("flush_inst", iss_inst, 64'd0);
        iss_stall = 1'b0;
        step();
        check("flush_drop_count", 64'(count), 64'd0);
        check("flush_drop_valid", 64'(iss_valid), 64'd0);

        // Queue works again after flush
        drive(2'b11, add1, C_ALU, 2'b11, D_RD, 1'b0, 8'd30, addi, C_ALU, 2'b01, D_RT, 1'b0, 8'd31);
        step(); idle();
        step();
        check("post_valid", 64'(iss_valid), 64'd3);
        check_lane("post_l0", 0, 1'b1, add1, 8'd30);
        check_lane("post_l1", 1, 1'b1, addi, 8'd31);
        check("post_count", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Parametrised successor to the two-wide issue stage: a circular instruction buffer between decode (IF/ID) and the execute pipes.
- Accepts groups of up to WIDTH decoded instructions per cycle and issues up to WIDTH per cycle, strictly in program order.
- Per cycle it enforces load-use, intra-group RAW/WAW and pipe-class (steer) hazards, and routes memory ops to lane 0 and branch-class ops to lane WIDTH-1.
- Replaces stall-and-replay with real buffering and a registered issue stage.

Parameters:
WIDTH, 2, enqueue and issue lanes (>=2)
DEPTH, 8, queue entries (power of 2, >= 2*WIDTH)
INST_WIDTH, 32, instruction bits
ADDR_WIDTH, 32, PC bits
ID_WIDTH, 8, instruction-id bits
REG_BITS, 5, register index bits; rs=[25:21], rt=[20:16], rd=[15:11]

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous pipeline flush
enq_valid  in  WIDTH  per-lane valid, contiguous from lane 0
enq_inst  in  WIDTH*INST_WIDTH  lane k at [k*INST_WIDTH +: INST_WIDTH]
enq_pc  in  WIDTH*ADDR_WIDTH  per-lane PC
enq_id  in  WIDTH*ID_WIDTH  per-lane instruction id
enq_class  in  2*WIDTH  00 alu, 01 memory, 10 branch/cmp/test, 11 nop
enq_src  in  2*WIDTH  bit0 rs read, bit1 rt read
enq_dst  in  2*WIDTH  00 none, 01 rt, 10 rd
enq_load  in  WIDTH  lane is a load (MEM_OP_READ)
enq_ready  out  1  queue can take a full group
iss_stall  in  1  downstream stall; freeze issue register
iss_valid  out  WIDTH  issue lane valid
iss_inst  out  WIDTH*INST_WIDTH  issued instruction, 0 when invalid
iss_pc  out  WIDTH*ADDR_WIDTH  issued PC, 0 when invalid
iss_id  out  WIDTH*ID_WIDTH  issued id, 0 when invalid
count  out  log2(DEPTH)+1  occupied entries
hazard  out  3  {steer, split, load}: why the oldest unissued entry is blocked this cycle

Behaviour:
- Reset (rst_n=0 at posedge):
  - head, tail and count go to 0.
  - All iss_* outputs go to 0.
  - The load scoreboard clears.
  - enq_ready=1.
- flush: same clearing as reset. Flush has priority over enqueue and issue in the same cycle; the enqueued group is dropped.
- enq_ready = (DEPTH - count) >= WIDTH, computed from the count register only. It does not account for same-cycle issue.
- Enqueue happens when enq_ready && enq_valid!=0. Valid lanes are written at tail in lane order, and tail advances by popcount(enq_valid) modulo DEPTH. Enqueue while !enq_ready is ignored.
- Selection is combinational over queue slots head+0 .. head+WIDTH-1, oldest first. Slot i is selected only if all of the following hold; the scan stops at the first failure:
  - i < count.
  - Every slot j<i is selected.
  - No RAW: no used src register of i equals the dst register of any selected j<i.
  - No WAW: dst of i differs from any selected non-none dst.
  - Load-use: no used src of i equals a register in the load scoreboard.
  - Steer: at most one memory-class and at most one branch-class op per cycle. With WIDTH=2, alu+memory and alu+branch are legal; memory+memory and branch+branch are not.
  - There is a free lane for i after routing.
- nop-class entries always select, occupy no lane and do not count toward issue width.
- Routing:
  - Memory goes to lane 0.
  - Branch goes to lane WIDTH-1.
  - ALU goes to the lowest free lane, in age order.
  - Lanes left unfilled issue zeros.
- Register update:
  - When !iss_stall, selected entries load the iss_* registers on the next posedge and head advances by the selected count.
  - When iss_stall=1, the iss_* registers, head and the scoreboard hold. Enqueue is still allowed.
- Latency: a group enqueued at edge N is visible on iss_* after edge N+1 at the earliest.
- Load scoreboard holds the dst registers of the loads issued at the last non-stalled edge (at most one). It is replaced on every non-stalled edge, which gives exactly one bubble for a load-use pair.
- count_next = count + enqueued - dequeued, with enqueue and dequeue allowed in the same cycle. Pointers wrap modulo DEPTH.
- hazard reports the first failing check for the oldest unselected valid slot, with priority load > split (RAW/WAW) > steer. It is 0 when the queue is empty or all examined slots are selected.
- Register 0 is treated as an ordinary register for hazard comparison.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, then release -> iss_valid=00, count=0, enq_ready=1, hazard=000.
2. Independent pair: enqueue {lane0 add r3=r1+r2, lane1 addi r5=r4+1} at edge 0 -> after edge 1, iss_valid=11, lane0 is add, lane1 is addi, count=0.
3. RAW split: enqueue {add r3=r1+r2, add r6=r3+r4} -> edge 1 issues lane0 only with hazard=010 beforehand; edge 2 issues the second add in lane0.
4. Steer swap: enqueue {jmp, lw r2,0(r1)} -> after edge 1, lane0=lw and lane1=jmp. Enqueue {lw, sw} -> issued on consecutive cycles, with hazard=100 between.
5. Load-use: enqueue {lw r2,0(r1), add r4=r2+r1} -> lw issues after edge 1, the add is blocked with hazard=001, and the add issues after edge 3.
6. Full/stall/flush: hold iss_stall=1 and enqueue 4 full groups -> count=8, enq_ready=0. Then assert flush with enq_valid=11 -> count=0, iss_valid=00, and the group is dropped.
